data_skew_buffer: RTL and testbench
===================================

Name: data_skew_buffer

Overview:
- Multi-lane skewing shift-register bank for the GEMM systolic array edge.
- Lane i delays its operand by BASE_DEPTH+i enabled cycles, producing the diagonal wavefront the PE grid expects.
- Adds per-lane valid tracking, zero-fill of bubbles, and a flush/drain state machine with completion pulse, so the controller can close a tile cleanly.

Parameters:
- NUM_LANES, 8, number of lanes (rows/cols fed), >=1
- DATA_WIDTH, 8, bits per lane element
- BASE_DEPTH, 1, delay of lane 0 in enabled cycles, >=1
- MAX_DELAY (localparam), BASE_DEPTH+NUM_LANES-1, deepest lane delay

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- en  input  1  global shift enable; all state, including counters, frozen when low
- valid_i  input  1  input wavefront valid, sampled only when en=1 and ready_o=1
- data_i  input  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- flush_i  input  1  request drain of all in-flight data
- ready_o  output  1  1 when not in DRAIN
- valid_o  output  NUM_LANES  per-lane valid, delayed identically to the lane data
- data_o  output  NUM_LANES*DATA_WIDTH  skewed lane data, same packing as data_i
- busy_o  output  1  OR of all internal valid bits, or state==DRAIN
- drain_done_o  output  1  single-cycle pulse at drain completion

Behaviour:
- Reset (reset=0 at posedge):
  - All data and valid stages cleared; state IDLE; drain counter 0.
  - Outputs: valid_o=0, data_o=0, busy_o=0, drain_done_o=0, ready_o=1.
  - Applies mid-drain too: no drain_done_o pulse is issued.
- Shift, on posedge with en=1: each lane shifts one stage.
  - Lane i output equals the lane i input accepted exactly BASE_DEPTH+i enabled cycles earlier.
  - Outputs are registered; no combinational path from inputs to outputs.
- Injected value per enabled cycle:
  - Accepted valid (valid_i=1 and ready_o=1): data_i with valid=1.
  - Otherwise: zero data with valid=0. Bubbles are always zero so PEs accumulate 0.
- en=0: nothing changes, including FSM and counter. drain_done_o is not re-asserted while frozen; it is cleared on the next posedge.
- FSM (transitions only on en=1 edges, except flush from IDLE, which is also en=1 only):
  - IDLE -> RUN on accepted valid.
  - IDLE with flush_i=1 -> drain_done_o=1 next cycle; stay IDLE.
  - RUN -> DRAIN on flush_i=1. flush has priority: valid_i in the same cycle is still accepted, then zeros follow.
  - RUN -> IDLE when, after the shift, all internal valid bits are 0 and no valid was accepted.
  - DRAIN:
    - ready_o=0; valid_i ignored; zeros injected.
    - Counter increments each enabled cycle from 0.
    - On reaching MAX_DELAY: state IDLE, counter 0, drain_done_o=1 for one cycle.
    - At that point all valid_o=0 and data_o=0.
    - flush_i during DRAIN is ignored; it does not restart the count.
- Counter width: $clog2(MAX_DELAY+1).
- NUM_LANES=1 and BASE_DEPTH=1 must elaborate: a single 1-stage lane.

Optional Feature:
- Macro DATA_SKEW_DESKEW_EN adds input port mode_i (1 bit).
- mode_i=0: skew; lane i delay = BASE_DEPTH+i.
- mode_i=1: deskew; lane i delay = BASE_DEPTH+(NUM_LANES-1-i). Used on the array output side to realign results.
- mode_i is latched only in IDLE. Changes while in RUN/DRAIN are ignored until the next return to IDLE.
- Without the macro: no mode_i port, skew mode only, no mode register.

Test Plan (NUM_LANES=4, DATA_WIDTH=8, BASE_DEPTH=1, en=1 unless stated):
- Single wavefront: data_i=0x44332211 with valid_i for 1 cycle, then 0.
  - Required: lane0 outputs 0x11 with valid 1 cycle later; lane1 0x22 at 2; lane2 0x33 at 3; lane3 0x44 at 4.
  - Zero/invalid at all other cycles; busy_o falls after cycle 4; state returns to IDLE.
- Stall: same stimulus with en=0 for 3 cycles after cycle 2.
  - Required: lane2/lane3 outputs appear 3 cycles late; no output changes while en=0.
- Flush: stream 6 valid wavefronts with flush_i asserted alongside the 6th.
  - Required: ready_o=0 for 4 enabled cycles; all 6 wavefronts emerge in full.
  - drain_done_o pulses exactly once; valid_o=0 afterwards.
- Flush in IDLE: flush_i for 1 cycle with busy_o=0.
  - Required: drain_done_o pulse next cycle; ready_o stays 1.
- Reset mid-drain: reset=0 two cycles into DRAIN.
  - Required: all outputs 0 next cycle, ready_o=1, no drain_done_o pulse.
- DATA_SKEW_DESKEW_EN with mode_i=1: single wavefront 0x44332211.
  - Required: lane3 at 1 cycle, lane0 at 4 cycles.
  - Toggling mode_i during RUN has no effect.

Source files
------------

// File: rtl/data_skew_buffer.sv
// Skewing shift-register bank for the systolic array edge: lane i delays by BASE_DEPTH+i enabled cycles.
// Optional DATA_SKEW_DESKEW_EN adds mode_i to reverse the lane delays (deskew on the output side).
module data_skew_lane #(
    parameter  int STAGES     = 1,
    parameter  int DATA_WIDTH = 8,
    localparam int TW         = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [TW-1:0]         i_tap,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_dat,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic                  o_any,
    output logic                  o_pre
);
    logic [STAGES-1:0]                 r_vld;
    logic [STAGES-1:0][DATA_WIDTH-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld <= '0;
            r_dat <= '0;
        end else if (i_en) begin
            r_vld[0] <= i_vld;
            r_dat[0] <= i_dat;
            for (int k = 1; k < STAGES; k++) begin
                // Stages past the active tap stay zero so a later mode change never exposes stale data
                if (k > int'(i_tap)) begin
                    r_vld[k] <= 1'b0;
                    r_dat[k] <= '0;
                end else begin
                    r_vld[k] <= r_vld[k-1];
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    always_comb begin
        o_any = 1'b0;
        o_pre = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (k <= int'(i_tap)) o_any = o_any | r_vld[k];
            if (k <  int'(i_tap)) o_pre = o_pre | r_vld[k];
        end
    end

    assign o_vld = r_vld[i_tap];
    assign o_dat = r_dat[i_tap];
endmodule

module data_skew_buffer #(
    parameter int NUM_LANES  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int BASE_DEPTH = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic                            valid_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_i,
    input  logic                            flush_i,
`ifdef DATA_SKEW_DESKEW_EN
    input  logic                            mode_i,
`endif
    output logic                            ready_o,
    output logic [NUM_LANES-1:0]            valid_o,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_o,
    output logic                            busy_o,
    output logic                            drain_done_o
);
    localparam int MAX_DELAY = BASE_DEPTH + NUM_LANES - 1;
    localparam int CW        = $clog2(MAX_DELAY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                          r_state;
    logic [CW-1:0]                   r_cnt;
    logic                            r_done;
    logic                            w_accept;
    logic [NUM_LANES*DATA_WIDTH-1:0] w_inj_dat;
    logic [NUM_LANES-1:0]            w_any;
    logic [NUM_LANES-1:0]            w_pre;
`ifdef DATA_SKEW_DESKEW_EN
    logic                            r_mode;
`endif

    // Bubbles and drain cycles inject zero data so the PEs accumulate nothing
    assign w_accept  = valid_i & (r_state != S_DRAIN);
    assign w_inj_dat = w_accept ? data_i : '0;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam int SKEW_D = BASE_DEPTH + g;
`ifdef DATA_SKEW_DESKEW_EN
        localparam int DESK_D = BASE_DEPTH + NUM_LANES - 1 - g;
        localparam int STAGES = (SKEW_D > DESK_D) ? SKEW_D : DESK_D;
`else
        localparam int STAGES = SKEW_D;
`endif
        localparam int TW = (STAGES > 1) ? $clog2(STAGES) : 1;
        logic [TW-1:0] w_tap;
`ifdef DATA_SKEW_DESKEW_EN
        assign w_tap = r_mode ? TW'(DESK_D - 1) : TW'(SKEW_D - 1);
`else
        assign w_tap = TW'(SKEW_D - 1);
`endif
        data_skew_lane #(.STAGES(STAGES), .DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk   (clk),
            .reset (reset),
            .i_en  (en),
            .i_tap (w_tap),
            .i_vld (w_accept),
            .i_dat (w_inj_dat[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_vld (valid_o[g]),
            .o_dat (data_o[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_any (w_any[g]),
            .o_pre (w_pre[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
`ifdef DATA_SKEW_DESKEW_EN
            r_mode  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (en) begin
                case (r_state)
                    S_IDLE: begin
`ifdef DATA_SKEW_DESKEW_EN
                        r_mode <= mode_i;
`endif
                        if (flush_i && w_accept) begin
                            r_state <= S_DRAIN;
                            r_cnt   <= '0;
                        end else if (flush_i) begin
                            r_done  <= 1'b1;
                        end else if (w_accept) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (flush_i) begin
                            r_state <= S_DRAIN;
                            r_cnt   <= '0;
                        end else if (!w_accept && !(|w_pre)) begin
                            // w_pre covers every stage that still holds data after this shift
                            r_state <= S_IDLE;
                        end
                    end
                    S_DRAIN: begin
                        if (r_cnt == CW'(MAX_DELAY - 1)) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ready_o      = (r_state != S_DRAIN);
    assign busy_o       = (|w_any) | (r_state == S_DRAIN);
    assign drain_done_o = r_done;
endmodule

// File: tb/tb_data_skew_buffer.sv
// Self-checking bench for data_skew_buffer (4 lanes x 8 bits, base depth 1): vector table,
// hand-written flush/reset sequences, and randomized traffic against a history-queue model.
module tb_data_skew_buffer;
    localparam int NL = 4, DW = 8, BD = 1, MAXD = BD + NL - 1;

    logic clk = 1'b0, reset = 1'b0, en = 1'b0, valid_i = 1'b0, flush_i = 1'b0;
    logic [NL*DW-1:0] data_i = '0;
    logic ready_o, busy_o, drain_done_o;
    logic [NL-1:0] valid_o;
    logic [NL*DW-1:0] data_o;
`ifdef DATA_SKEW_DESKEW_EN
    logic mode_i = 1'b0;
`endif

    always #5 clk = ~clk;

    data_skew_buffer #(.NUM_LANES(NL), .DATA_WIDTH(DW), .BASE_DEPTH(BD)) dut (
        .clk(clk), .reset(reset), .en(en), .valid_i(valid_i), .data_i(data_i), .flush_i(flush_i),
`ifdef DATA_SKEW_DESKEW_EN
        .mode_i(mode_i),
`endif
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .busy_o(busy_o),
        .drain_done_o(drain_done_o));

    int n_tests = 0, n_fail = 0;

    // Model: hist[k] is what was injected k+1 enabled edges ago; lane i shows hist[delay_i-1]
    typedef struct packed { logic v; logic [NL*DW-1:0] d; } inj_t;
    typedef enum { M_IDLE, M_RUN, M_DRAIN } mst_t;
    inj_t hist[$];
    mst_t ms = M_IDLE;
    int   drain_left = 0;
    logic m_done = 1'b0, m_mode = 1'b0;

    function automatic int dly(int i);
        return m_mode ? (BD + NL - 1 - i) : (BD + i);
    endfunction

    function automatic logic window_valid();
        foreach (hist[k]) if (hist[k].v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic acc;
        if (!reset) begin
            hist.delete(); ms = M_IDLE; drain_left = 0; m_done = 1'b0; m_mode = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (!en) return;
        acc = valid_i && (ms != M_DRAIN);
`ifdef DATA_SKEW_DESKEW_EN
        if (ms == M_IDLE) m_mode = mode_i;
`endif
        hist.push_front('{acc, acc ? data_i : '0});
        if (hist.size() > MAXD) void'(hist.pop_back());
        if (ms == M_DRAIN) begin
            drain_left--;
            if (drain_left == 0) begin ms = M_IDLE; m_done = 1'b1; end
        end else if (flush_i) begin
            if (ms == M_RUN || acc) begin ms = M_DRAIN; drain_left = MAXD; end
            else m_done = 1'b1;
        end else if (acc) ms = M_RUN;
        else if (ms == M_RUN && !window_valid()) ms = M_IDLE;
    endtask

    task automatic check_model();
        logic [NL-1:0] xv;
        logic [NL*DW-1:0] xd;
        xv = '0; xd = '0;
        for (int i = 0; i < NL; i++)
            if (hist.size() >= dly(i)) begin
                xv[i] = hist[dly(i)-1].v;
                xd[i*DW +: DW] = hist[dly(i)-1].d[i*DW +: DW];
            end
        chk("model valid_o", valid_o, xv);
        chk("model data_o", data_o, xd);
        chk("model ready_o", ready_o, ms != M_DRAIN);
        chk("model busy_o", busy_o, window_valid() || ms == M_DRAIN);
        chk("model drain_done_o", drain_done_o, m_done);
    endtask

    task automatic cyc(input logic e, input logic v, input logic f, input logic [NL*DW-1:0] d);
        en = e; valid_i = v; flush_i = f; data_i = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    function automatic logic [NL*DW-1:0] wave(int k);
        logic [7:0] b;
        b = 8'(k);
        return {8'h41 + b, 8'h31 + b, 8'h21 + b, 8'h11 + b};
    endfunction

    typedef struct {
        logic e, v, f; logic [31:0] d;
        logic [3:0] xv; logic [31:0] xd; logic xr, xb;
    } vec_t;
    vec_t tbl[$];

    int got[NL];
    int rdy_lo, dones;

    task automatic collect();
        logic [NL*DW-1:0] w;
        if (!ready_o) rdy_lo++;
        if (drain_done_o) dones++;
        for (int i = 0; i < NL; i++)
            if (valid_o[i]) begin
                w = wave(got[i]);
                chk("flush lane data", data_o[i*DW +: DW], w[i*DW +: DW]);
                got[i]++;
            end
    endtask

    initial begin
        // single wavefront, junk data on bubbles must come out as zero
        tbl.push_back('{1,1,0,32'h44332211, 4'b0001,32'h00000011, 1,1});
        tbl.push_back('{1,0,0,32'hFFFFFFFF, 4'b0010,32'h00002200, 1,1});
        tbl.push_back('{1,0,0,32'hFFFFFFFF, 4'b0100,32'h00330000, 1,1});
        tbl.push_back('{1,0,0,32'h00000000, 4'b1000,32'h44000000, 1,1});
        tbl.push_back('{1,0,0,32'h00000000, 4'b0000,32'h00000000, 1,0});
        tbl.push_back('{1,0,0,32'h00000000, 4'b0000,32'h00000000, 1,0});
        // stall for 3 cycles after cycle 2; valid_i while frozen is not sampled
        tbl.push_back('{1,1,0,32'h44332211, 4'b0001,32'h00000011, 1,1});
        tbl.push_back('{1,0,0,32'h00000000, 4'b0010,32'h00002200, 1,1});
        tbl.push_back('{0,1,0,32'hDEADBEEF, 4'b0010,32'h00002200, 1,1});
        tbl.push_back('{0,0,0,32'h00000000, 4'b0010,32'h00002200, 1,1});
        tbl.push_back('{0,0,0,32'h00000000, 4'b0010,32'h00002200, 1,1});
        tbl.push_back('{1,0,0,32'h00000000, 4'b0100,32'h00330000, 1,1});
        tbl.push_back('{1,0,0,32'h00000000, 4'b1000,32'h44000000, 1,1});
        tbl.push_back('{1,0,0,32'h00000000, 4'b0000,32'h00000000, 1,0});

        // reset state
        cyc(1, 0, 0, '0);
        cyc(1, 1, 0, 32'h12345678);
        chk("reset valid_o", valid_o, '0);
        chk("reset data_o", data_o, '0);
        chk("reset ready_o", ready_o, 1'b1);
        chk("reset busy_o", busy_o, 1'b0);
        chk("reset drain_done_o", drain_done_o, 1'b0);
        reset = 1'b1;

        foreach (tbl[r]) begin
            cyc(tbl[r].e, tbl[r].v, tbl[r].f, tbl[r].d);
            chk($sformatf("vec%0d valid_o", r), valid_o, tbl[r].xv);
            chk($sformatf("vec%0d data_o", r), data_o, tbl[r].xd);
            chk($sformatf("vec%0d ready_o", r), ready_o, tbl[r].xr);
            chk($sformatf("vec%0d busy_o", r), busy_o, tbl[r].xb);
        end

        // flush alongside the 6th wavefront; junk valid and a repeat flush during drain are ignored
        for (int i = 0; i < NL; i++) got[i] = 0;
        rdy_lo = 0; dones = 0;
        for (int k = 0; k < 6; k++) begin cyc(1, 1, k == 5, wave(k)); collect(); end
        for (int j = 0; j < 10; j++) begin cyc(1, j < 3, j == 1, 32'hA5A5A5A5); collect(); end
        chk("flush ready low cycles", rdy_lo, 4);
        chk("flush done pulses", dones, 1);
        for (int i = 0; i < NL; i++) chk($sformatf("flush lane%0d count", i), got[i], 6);
        chk("flush valid_o after", valid_o, '0);

        // flush while idle: pulse next cycle, cleared on next edge even while frozen
        chk("idle busy before flush", busy_o, 1'b0);
        cyc(1, 0, 1, '0);
        chk("idle flush done", drain_done_o, 1'b1);
        chk("idle flush ready", ready_o, 1'b1);
        cyc(0, 0, 0, '0);
        chk("idle flush done cleared", drain_done_o, 1'b0);

        // reset two cycles into drain
        cyc(1, 1, 0, wave(0));
        cyc(1, 1, 1, wave(1));
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        chk("pre-reset ready low", ready_o, 1'b0);
        reset = 1'b0;
        cyc(1, 0, 0, '0);
        chk("mid-drain reset valid_o", valid_o, '0);
        chk("mid-drain reset data_o", data_o, '0);
        chk("mid-drain reset ready_o", ready_o, 1'b1);
        chk("mid-drain reset busy_o", busy_o, 1'b0);
        reset = 1'b1;
        dones = 0;
        for (int j = 0; j < 6; j++) begin cyc(1, 0, 0, '0); if (drain_done_o) dones++; end
        chk("no done after reset", dones, 0);

`ifdef DATA_SKEW_DESKEW_EN
        // deskew: lane3 first, lane0 last; mode toggles during RUN ignored
        mode_i = 1'b1;
        cyc(1, 1, 0, 32'h44332211);
        chk("deskew e1", {valid_o, data_o}, {4'b1000, 32'h44000000});
        mode_i = 1'b0;
        cyc(1, 0, 0, '0);
        chk("deskew e2", {valid_o, data_o}, {4'b0100, 32'h00330000});
        mode_i = 1'b1;
        cyc(1, 0, 0, '0);
        chk("deskew e3", {valid_o, data_o}, {4'b0010, 32'h00002200});
        mode_i = 1'b0;
        cyc(1, 0, 0, '0);
        chk("deskew e4", {valid_o, data_o}, {4'b0001, 32'h00000011});
        cyc(1, 0, 0, '0);
        chk("deskew e5", {valid_o, data_o, busy_o}, {4'b0000, 32'h0, 1'b0});
`endif

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 199) != 0);
`ifdef DATA_SKEW_DESKEW_EN
            mode_i = 1'($urandom_range(0, 1));
`endif
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
